// File: rtl/rom_boot_loader.sv
// rtl/rom_boot_loader.sv - byte-stream program image loader for instruction ROM
module rom_boot_loader #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    input  logic              restart_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_hold_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       words_o
);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 1);

    state_t      state, state_next;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] words;
    logic [31:0] wdata;
    logic [1:0]  byte_idx;
    logic [7:0]  csum;
    logic [TW-1:0] tcnt;

    logic        ready_st;
    logic        accept;
    logic        counting;
    logic        timeout_hit;
    logic [15:0] len_next;
    logic        last_word;

    // Readiness depends only on the state; held low while the async reset is asserted
    assign ready_st   = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CSUM);
    assign rx_ready_o = ready_st & rst_i;
    assign accept     = rx_valid_i & rx_ready_o;

    // Idle timer runs only once a frame has started and a byte is awaited
    assign counting    = (state == S_LEN_HI) || (state == S_DATA) || (state == S_CSUM);
    assign timeout_hit = counting & ~accept & (tcnt == TCNT_LAST);

    assign len_next  = {rx_data_i, len_lo};
    assign last_word = ({16'd0, words} + 32'd1) == {16'd0, len};

    assign mem_we_o    = (state == S_WRITE);
    assign mem_addr_o  = words[ADDR_W-1:0];
    assign mem_wdata_o = wdata;
    assign done_o      = (state == S_DONE);
    assign err_o       = (state == S_ERR);
    assign core_hold_o = (state != S_DONE);
    assign words_o     = words;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_LEN_LO;
        end else begin
            state <= state_next;
        end
    end

    // Frame parser next-state; restart overrides everything including a same-cycle byte
    always_comb begin
        state_next = state;
        case (state)
            S_LEN_LO: begin
                if (accept) state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (accept) begin
                    if ({16'd0, len_next} > CAPACITY) state_next = S_ERR;
                    else if (len_next == 16'd0)       state_next = S_CSUM;
                    else                              state_next = S_DATA;
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end
            S_DATA: begin
                if (accept) begin
                    if (byte_idx == 2'd3) state_next = S_WRITE;
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end
            S_WRITE: begin
                state_next = last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = (rx_data_i == csum) ? S_DONE : S_ERR;
                end else if (timeout_hit) begin
                    state_next = S_ERR;
                end
            end
            S_DONE:  state_next = S_DONE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_ERR;
        endcase
        if (restart_i) state_next = S_LEN_LO;
    end

    // Datapath: length capture, word assembly, running checksum, idle timer, word count
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            len_lo   <= 8'd0;
            len      <= 16'd0;
            words    <= 16'd0;
            wdata    <= 32'd0;
            byte_idx <= 2'd0;
            csum     <= 8'd0;
            tcnt     <= '0;
        end else if (restart_i) begin
            len_lo   <= 8'd0;
            len      <= 16'd0;
            words    <= 16'd0;
            byte_idx <= 2'd0;
            csum     <= 8'd0;
            tcnt     <= '0;
        end else begin
            if (accept) begin
                tcnt <= '0;
                if (state != S_CSUM) csum <= csum ^ rx_data_i;
                case (state)
                    S_LEN_LO: len_lo <= rx_data_i;
                    S_LEN_HI: len    <= len_next;
                    S_DATA: begin
                        wdata[{byte_idx, 3'b000} +: 8] <= rx_data_i;
                        byte_idx <= byte_idx + 2'd1;
                    end
                    default: ;
                endcase
            end else if (counting) begin
                tcnt <= tcnt + 1'b1;
            end
            if (state == S_WRITE) words <= words + 16'd1;
        end
    end

endmodule

// File: tb/tb_rom_boot_loader.sv
// tb/tb_rom_boot_loader.sv - directed self-checking bench for rom_boot_loader
module tb_rom_boot_loader;

    localparam int ADDR_W      = 4;
    localparam int TIMEOUT_CYC = 100;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [7:0]        rx_data_i = 8'd0;
    logic              rx_valid_i = 1'b0;
    logic              rx_ready_o;
    logic              restart_i = 1'b0;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              core_hold_o;
    logic              done_o;
    logic              err_o;
    logic [15:0]       words_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    rom_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .restart_i   (restart_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .core_hold_o (core_hold_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .words_o     (words_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (mem_we_o) begin
            wr_addr.push_back(32'(mem_addr_o));
            wr_data.push_back(mem_wdata_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk_i);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 50) check("ready_timeout", 32'(rx_ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic pulse_restart();
        @(negedge clk_i);
        restart_i = 1'b1;
        @(negedge clk_i);
        restart_i = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic send_frame_a(input logic [7:0] cs);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h6F); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(cs);
    endtask

    task automatic check_frame_a_writes(input string tag);
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({tag, "_a0"}, wr_addr[0], 32'd0);
            check({tag, "_d0"}, wr_data[0], 32'h0000_0013);
            check({tag, "_a1"}, wr_addr[1], 32'd1);
            check({tag, "_d1"}, wr_data[1], 32'h0000_006F);
        end
    endtask

    initial begin
        logic [7:0]  cs;
        logic [31:0] w;

        // Reset values while reset is asserted
        #12;
        check("rst_ready", 32'(rx_ready_o), 32'd0);
        check("rst_we",    32'(mem_we_o), 32'd0);
        check("rst_addr",  32'(mem_addr_o), 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_hold",  32'(core_hold_o), 32'd1);
        check("rst_done",  32'(done_o), 32'd0);
        check("rst_err",   32'(err_o), 32'd0);
        check("rst_words", 32'(words_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("idle_ready", 32'(rx_ready_o), 32'd1);

        // Valid two-word frame
        send_frame_a(8'h7E);
        idle(2);
        check_frame_a_writes("frA");
        check("frA_done",  32'(done_o), 32'd1);
        check("frA_hold",  32'(core_hold_o), 32'd0);
        check("frA_words", 32'(words_o), 32'd2);
        check("frA_ready", 32'(rx_ready_o), 32'd0);
        check("frA_err",   32'(err_o), 32'd0);

        // Restart clears status
        pulse_restart();
        check("rs_done",  32'(done_o), 32'd0);
        check("rs_words", 32'(words_o), 32'd0);
        check("rs_hold",  32'(core_hold_o), 32'd1);
        check("rs_ready", 32'(rx_ready_o), 32'd1);

        // Bad checksum
        send_frame_a(8'h7F);
        idle(2);
        check("bad_err",   32'(err_o), 32'd1);
        check("bad_done",  32'(done_o), 32'd0);
        check("bad_hold",  32'(core_hold_o), 32'd1);
        check("bad_ready", 32'(rx_ready_o), 32'd0);
        idle(10);
        check("bad_nwr", 32'(wr_addr.size()), 32'd2);

        // Empty image
        pulse_restart();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        idle(2);
        check("empty_done",  32'(done_o), 32'd1);
        check("empty_nwr",   32'(wr_addr.size()), 32'd0);
        check("empty_words", 32'(words_o), 32'd0);

        // Oversize length (17 > 16)
        pulse_restart();
        send_byte(8'h11); send_byte(8'h00);
        check("big_err",  32'(err_o), 32'd1);
        idle(5);
        check("big_nwr",   32'(wr_addr.size()), 32'd0);
        check("big_ready", 32'(rx_ready_o), 32'd0);

        // Full-capacity image: 16 words, last address 15
        pulse_restart();
        cs = 8'h10;
        send_byte(8'h10); send_byte(8'h00);
        for (int i = 0; i < 16; i++) begin
            w = {8'hA5, 8'(i), ~8'(i), 8'(i + 16)};
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8]);
                cs = cs ^ w[8*k +: 8];
            end
        end
        send_byte(cs);
        idle(2);
        check("full_done",  32'(done_o), 32'd1);
        check("full_words", 32'(words_o), 32'd16);
        check("full_nwr",   32'(wr_addr.size()), 32'd16);
        if (wr_addr.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("full_a%0d", i), wr_addr[i], 32'(i));
                check($sformatf("full_d%0d", i), wr_data[i], {8'hA5, 8'(i), ~8'(i), 8'(i + 16)});
            end
        end

        // Timeout after second data byte, then recovery
        pulse_restart();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
        repeat (TIMEOUT_CYC - 5) @(posedge clk_i);
        #1;
        check("to_early", 32'(err_o), 32'd0);
        repeat (10) @(posedge clk_i);
        #1;
        check("to_err", 32'(err_o), 32'd1);
        pulse_restart();
        send_frame_a(8'h7E);
        idle(2);
        check("to_rec_done", 32'(done_o), 32'd1);
        check_frame_a_writes("to_rec");

        // Async reset mid-DATA
        pulse_restart();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h13); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h00);
        idle(2);
        send_byte(8'h55);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("mr_ready", 32'(rx_ready_o), 32'd0);
        check("mr_words", 32'(words_o), 32'd0);
        check("mr_addr",  32'(mem_addr_o), 32'd0);
        check("mr_wdata", mem_wdata_o, 32'd0);
        check("mr_hold",  32'(core_hold_o), 32'd1);
        check("mr_we",    32'(mem_we_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        send_frame_a(8'h7E);
        idle(2);
        check("mr_done", 32'(done_o), 32'd1);
        check_frame_a_writes("mr");

        // Restart coinciding with an accepted byte drops the byte
        pulse_restart();
        @(negedge clk_i);
        rx_data_i  = 8'h05;
        rx_valid_i = 1'b1;
        restart_i  = 1'b1;
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        restart_i  = 1'b0;
        send_frame_a(8'h7E);
        idle(2);
        check("rp_done", 32'(done_o), 32'd1);
        check_frame_a_writes("rp");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
